// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory read port and the IF/ID load port.
// The master side is the fetch unit; the slave side is memory plus the IF/ID latch.
interface fetch_unit_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        ifid_load;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instruction;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_rdata,
        input  imem_resp,
        output ifid_load,
        output ifid_pc,
        output ifid_instruction
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_rdata,
        output imem_resp,
        input  ifid_load,
        input  ifid_pc,
        input  ifid_instruction
    );
endinterface

// File: rtl/fetch_unit.sv
// LC-3b fetch stage: issues reads at PC, buffers a word across IF/ID stalls,
// and drains an outstanding read before honouring a redirect.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] pend_q, pend_d;

    logic [15:0] pc_inc;
    logic        load;
    logic        read;
    logic [15:0] instr;

    assign pc_inc = pc_q + 16'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= 16'h0000;
            buf_q   <= 16'h0000;
            pend_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        load    = 1'b0;
        read    = 1'b1;
        instr   = bus.imem_rdata;

        unique case (state_q)
            FETCH: begin
                if (bus.imem_resp) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (!stall) begin
                        load = 1'b1;
                        pc_d = pc_inc;
                    end else begin
                        buf_d   = bus.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Read cannot be aborted; park the target until it lands.
                    pend_d  = redirect_pc;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                read  = 1'b0;
                instr = buf_q;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    load    = 1'b1;
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (bus.imem_resp) begin
                    pc_d    = redirect ? redirect_pc : pend_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = redirect_pc;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Memory shares this reset, but never present a stale word while it is held.
    assign bus.ifid_load        = load & ~reset;
    assign bus.ifid_pc          = pc_inc;
    assign bus.ifid_instruction = instr;
    assign bus.imem_read        = read;
    assign bus.imem_address     = pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: stall  input  1  IF/ID latch cannot accept a new instruction this cycle.
REQ-004 SHALL have port: redirect  input  1  control-transfer request from a later stage.
REQ-005 SHALL have port: redirect_pc  input  16 (lc3b_word)  target address, valid when redirect=1.
REQ-006 SHALL have port: imem_read  output  1  instruction memory read request.
REQ-007 SHALL have port: imem_address  output  16  read address, equal to the current fetch PC.
REQ-008 SHALL have port: imem_rdata  input  16  instruction word, valid when imem_resp=1.
REQ-009 SHALL have port: imem_resp  input  1  one-cycle read completion.
REQ-010 SHALL have port: ifid_load  output  1  load strobe to IF/ID latch.
REQ-011 SHALL have port: ifid_pc  output  16  fetch PC + 2 of the delivered instruction.
REQ-012 SHALL have port: ifid_instruction  output  16  delivered instruction word.

Function
REQ-013 SHALL hold a 16-bit PC register, a 16-bit instruction buffer, a 16-bit pending-target register and a state register with states FETCH, HOLD, DRAIN.
REQ-014 SHALL drive imem_address = PC in all states; imem_read=1 in FETCH and DRAIN, 0 in HOLD.
REQ-015 SHALL keep imem_address stable while imem_read=1 until imem_resp=1 (no request abort).
REQ-016 FETCH, imem_resp=1, redirect=0, stall=0: ifid_load=1 same cycle, ifid_instruction=imem_rdata, ifid_pc=PC+2; PC<=PC+2; stay FETCH.
REQ-017 FETCH, imem_resp=1, redirect=0, stall=1: ifid_load=0; buffer<=imem_rdata; -> HOLD.
REQ-018 HOLD, redirect=0, stall=0: ifid_load=1, ifid_instruction=buffer, ifid_pc=PC+2; PC<=PC+2; -> FETCH.
REQ-019 HOLD, redirect=0, stall=1: ifid_load=0; all registers unchanged.
REQ-020 FETCH with imem_resp=1 and redirect=1, or HOLD with redirect=1: ifid_load=0, fetched/buffered word discarded, PC<=redirect_pc, -> FETCH.
REQ-021 FETCH with imem_resp=0 and redirect=1: pending-target<=redirect_pc; -> DRAIN.
REQ-022 DRAIN: ifid_load=0 always; redirect=1 overwrites pending-target (latest wins); on imem_resp=1 response discarded, PC<=redirect_pc if redirect=1 that cycle else pending-target, -> FETCH.
REQ-023 redirect SHALL take priority over stall in every state.
REQ-024 ifid_load SHALL be 0 whenever no valid undiscarded instruction is presented; ifid_pc and ifid_instruction are don't-care when ifid_load=0.
REQ-025 PC+2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000); bit 0 of redirect_pc SHALL be passed through unmodified.
REQ-026 ifid_load, ifid_pc, ifid_instruction, imem_read, imem_address SHALL be combinational from state, registers and inputs; no path from imem_rdata to imem_address.

Reset
REQ-027 reset=1 SHALL immediately, independent of clk: PC=0x0000, buffer=0x0000, pending-target=0x0000, state=FETCH.
REQ-028 During and after reset SHALL drive imem_read=1, imem_address=0x0000, ifid_load=0 until first imem_resp.
REQ-029 Reset mid-operation (any state, request outstanding) SHALL discard all in-flight data; instruction memory is reset by the same signal.

Verification
REQ-030 Stream: reset, memory resp every cycle with data 0x1000+addr, stall=0 -> ifid_load each resp, ifid_pc 0x0002, 0x0004, 0x0006; ifid_instruction 0x1000, 0x1002, 0x1004.
REQ-031 Stall: resp at PC=0x0004 with stall=1 for 3 cycles -> imem_read=0 in HOLD, ifid_load=0 for 3 cycles, then one ifid_load with buffered word, ifid_pc=0x0006.
REQ-032 Redirect with resp: PC=0x0010, resp and redirect=1, redirect_pc=0x0400 same cycle -> ifid_load=0, next imem_address=0x0400.
REQ-033 Redirect during wait: PC=0x0010, resp latency 4, redirect 0x0400 then 0x0800 in DRAIN -> imem_address held 0x0010 until resp, no ifid_load, next address 0x0800.
REQ-034 Wrap: PC=0xFFFE, resp, stall=0 -> ifid_pc=0x0000, next imem_address=0x0000.
REQ-035 Async reset in HOLD between clock edges -> state FETCH, imem_address=0x0000 before next edge, ifid_load=0.
